fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch front-end that sits directly upstream of the instruction cache and downstream of it on the instruction path.
- Owns the fetch PC and drives the icache CPU-side request.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects and FENCE.I: the queue is flushed and the icache is sent an invalidate pulse.

Parameters:
- ADDR_WIDTH, 32, PC / icache address width
- DATA_WIDTH, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- redirect  in  1  branch/jump/trap taken; load redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch PC; bits [1:0] are ignored and forced to 0
- fence_i  in  1  FENCE.I retired; acts as a redirect to redirect_pc plus an icache invalidate
- ic_addr  out  ADDR_WIDTH  icache cpu_addr
- ic_req  out  1  icache cpu_req
- ic_data  in  DATA_WIDTH  icache cpu_data
- ic_valid  in  1  icache cpu_valid; combinational, same cycle as request
- ic_stall  in  1  icache cpu_stall; informational, used for the stall counter only
- ic_invalidate  out  1  icache invalidate, one-cycle pulse
- dec_valid  out  1  head entry valid
- dec_instr  out  DATA_WIDTH  head instruction
- dec_pc  out  ADDR_WIDTH  head PC
- dec_ready  in  1  decode accepts head
- fq_count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- stall_cycles  out  32  saturating count of cycles with ic_req && ic_stall

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - fetch_pc = RESET_PC; FIFO empty, so dec_valid = 0 and fq_count = 0.
  - dec_instr = 0 and dec_pc = 0 while empty.
  - ic_invalidate = 0; stall_cycles = 0.
  - ic_req = 0 during the reset cycle, then 1 from the first cycle after reset.
- Request: ic_addr = fetch_pc always. ic_req = !rst && !inval_pending && (fq_count < DEPTH).
  - There is no combinational path from dec_ready to ic_req.
- Push: when ic_req && ic_valid && !redirect && !fence_i:
  - write {fetch_pc, ic_data} at the tail;
  - fetch_pc += 4, wrapping modulo 2^ADDR_WIDTH.
  - Hit latency is one cycle: the hit is seen in cycle N and dec_valid is asserted in N+1.
- Miss: ic_valid = 0, so fetch_pc is held and the request is repeated every cycle until the icache returns valid.
- Pop: when dec_valid && dec_ready, advance the head. dec_* come from registered FIFO storage.
- Push and pop in the same cycle: both occur and fq_count is unchanged.
  - This is legal when full, but the push cannot occur when full because ic_req = 0.
- Redirect, when redirect = 1 or fence_i = 1:
  - FIFO flushed (count 0, pointers reset); any same-cycle push and pop are discarded.
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - dec_valid = 0 the next cycle; requests resume the next cycle.
  - A redirect issued during an icache miss simply changes ic_addr. The icache finishes its refill and re-evaluates the new address, so no extra handshake is needed.
- fence_i additionally:
  - inval_pending is set for exactly one cycle and ic_invalidate = 1 in that cycle;
  - ic_req = 0 in that cycle;
  - requests resume at the redirect PC the following cycle.
  - Sequence: fence_i in cycle N, invalidate in N+1, request in N+2.
- fence_i and redirect together: fence_i behaviour applies; the target is redirect_pc.
- A second redirect or fence_i during the pending cycle: the new target wins.
  - For fence_i, the pulse is repeated for one more cycle.
- rst has priority over everything, including mid-miss and inval_pending.
- stall_cycles saturates at 32'hFFFF_FFFF and clears only on rst.

Decomposition:
- Package fetch_pkg holds:
  - PC_STEP = 4;
  - entry layout with fields pc and instr, width ADDR_WIDTH + DATA_WIDTH;
  - the localparam for the count width.
- Sub-module fetch_fifo holds the storage:
  - parameters DEPTH and WIDTH;
  - ports push, push_data, pop, flush, head_data, empty, full, count;
  - flush has priority over push and pop.
- fetch_queue itself holds:
  - the PC register and redirect/fence logic;
  - request gating;
  - the stall counter.

Test Plan:
- Reset then 6 consecutive hits, with dec_ready = 1 from cycle 2 -> dec_pc sequence 0x0, 0x4, 0x8, ... one per cycle, first dec_valid exactly one cycle after the first hit, fq_count ≤ 2.
- dec_ready = 0, hits continuous -> fq_count reaches 4, ic_req drops to 0, fetch_pc held at 0x10; raise dec_ready -> ic_req returns the cycle after the first pop.
- Miss for 5 cycles at 0x40 -> ic_addr stays 0x40 and ic_req stays 1; stall_cycles increments by 5; no push until ic_valid.
- Redirect to 0x1003 with 3 entries queued and same-cycle ic_valid -> next cycle fq_count = 0 and dec_valid = 0; then ic_addr = 0x1000; the discarded push never appears at decode.
- fence_i with redirect_pc = 0x200 in cycle N -> ic_invalidate = 1 and ic_req = 0 in N+1, ic_req = 1 with ic_addr = 0x200 in N+2, queue empty.
- Assert rst during an active miss with 2 entries queued -> next cycle fq_count = 0, ic_addr = RESET_PC, ic_invalidate = 0, stall_cycles = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
// A queue entry is {pc, instr}, with the PC in the upper bits.
package fetch_pkg;

  localparam int unsigned PC_STEP = 4;

  // Entry layout at the default 32/32 widths.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Occupancy counter width: counts 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {pc, instr} entries.
// Flush and reset clear the control state only; storage contents are left as-is.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // When full, a push is only accepted together with a pop.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, drives the icache request,
// buffers returned instructions and handles redirects and FENCE.I.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   fence_i,
  output logic [ADDR_WIDTH-1:0]  ic_addr,
  output logic                   ic_req,
  input  logic [DATA_WIDTH-1:0]  ic_data,
  input  logic                   ic_valid,
  input  logic                   ic_stall,
  output logic                   ic_invalidate,
  output logic                   dec_valid,
  output logic [DATA_WIDTH-1:0]  dec_instr,
  output logic [ADDR_WIDTH-1:0]  dec_pc,
  input  logic                   dec_ready,
  output logic [$clog2(DEPTH):0] fq_count,
  output logic [31:0]            stall_cycles
);

  localparam int ENTRY_W = entry_width(ADDR_WIDTH, DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inval_pending_q, inval_pending_d;
  logic [31:0]           stall_q, stall_d;

  logic                  flush, push, pop;
  logic                  fifo_empty, fifo_full;
  logic [ENTRY_W-1:0]    head_data;

  assign flush = redirect || fence_i;

  // Gated only by registered state so decode never sees a path back to ic_req.
  assign ic_req  = !rst && !inval_pending_q && !fifo_full;
  assign ic_addr = fetch_pc_q;
  assign push    = ic_req && ic_valid && !flush;
  assign pop     = dec_valid && dec_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fetch_pc_q, ic_data}),
    .pop       (pop),
    .flush     (flush),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fq_count)
  );

  assign dec_valid     = !fifo_empty;
  assign dec_pc        = fifo_empty ? '0 : head_data[ENTRY_W-1 -: ADDR_WIDTH];
  assign dec_instr     = fifo_empty ? '0 : head_data[DATA_WIDTH-1:0];
  assign ic_invalidate = inval_pending_q;
  assign stall_cycles  = stall_q;

  // A redirect overrides any in-flight push; a repeated fence_i re-arms the pulse.
  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    inval_pending_d = 1'b0;
    if (flush) begin
      fetch_pc_d      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      inval_pending_d = fence_i;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (ic_req && ic_stall && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q      <= RESET_PC;
      inval_pending_q <= 1'b0;
      stall_q         <= '0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      inval_pending_q <= inval_pending_d;
      stall_q         <= stall_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard of fetched {pc, instr} entries.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, redirect, fence_i, ic_valid, ic_stall, dec_ready;
  logic [31:0] redirect_pc, ic_data;
  logic [31:0] ic_addr, dec_instr, dec_pc, stall_cycles;
  logic        ic_req, ic_invalidate, dec_valid;
  logic [2:0]  fq_count;

  fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .fence_i      (fence_i),
    .ic_addr      (ic_addr),
    .ic_req       (ic_req),
    .ic_data      (ic_data),
    .ic_valid     (ic_valid),
    .ic_stall     (ic_stall),
    .ic_invalidate(ic_invalidate),
    .dec_valid    (dec_valid),
    .dec_instr    (dec_instr),
    .dec_pc       (dec_pc),
    .dec_ready    (dec_ready),
    .fq_count     (fq_count),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  fetch_entry_t sb[$];
  logic [31:0]  m_pc    = 32'h0;
  logic         m_inval = 1'b0;
  logic [31:0]  m_stall = 32'h0;
  bit           armed   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, score the transfers, advance the model.
  task automatic tick();
    logic         mreq, mpush, mpop;
    fetch_entry_t e;
    #1;
    mreq = !rst && !m_inval && (sb.size() < 4);
    if (armed) begin
      chk("ic_req", ic_req, mreq);
      chk("ic_addr", ic_addr, m_pc);
      chk("ic_invalidate", ic_invalidate, m_inval);
      chk("dec_valid", dec_valid, sb.size() != 0);
      chk("fq_count", fq_count, sb.size());
      chk("stall_cycles", stall_cycles, m_stall);
      if (sb.size() == 0) begin
        chk("dec_pc_empty", dec_pc, 0);
        chk("dec_instr_empty", dec_instr, 0);
      end
    end
    mpush = mreq && ic_valid && !redirect && !fence_i;
    mpop  = (sb.size() != 0) && dec_ready && !redirect && !fence_i && !rst;
    if (armed && mpop) begin
      chk("dec_pc", dec_pc, sb[0].pc);
      chk("dec_instr", dec_instr, sb[0].instr);
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_pc    = 32'h0;
      m_inval = 1'b0;
      m_stall = 32'h0;
      armed   = 1'b1;
    end else begin
      if (mreq && ic_stall && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (redirect || fence_i) begin
        sb.delete();
        m_pc    = {redirect_pc[31:2], 2'b00};
        m_inval = fence_i;
      end else begin
        m_inval = 1'b0;
        if (mpop) void'(sb.pop_front());
        if (mpush) begin
          e.pc    = m_pc;
          e.instr = ic_data;
          sb.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    #1;
    ic_data = $urandom;
  endtask

  int          maxcnt;
  logic [31:0] stall0;

  initial begin
    rst = 1'b1; redirect = 1'b0; fence_i = 1'b0; redirect_pc = '0;
    ic_valid = 1'b0; ic_stall = 1'b0; dec_ready = 1'b0; ic_data = $urandom;
    tick();
    tick();
    chk("reset_dec_valid", dec_valid, 0);
    chk("reset_fq_count", fq_count, 0);
    chk("reset_ic_addr", ic_addr, 32'h0);
    rst = 1'b0;

    // Six back-to-back hits, decode ready from the second cycle.
    ic_valid = 1'b1;
    maxcnt = 0;
    for (int i = 0; i < 6; i++) begin
      dec_ready = (i >= 1);
      tick();
      if (i == 0) begin
        chk("t1_first_valid", dec_valid, 1);
        chk("t1_first_pc", dec_pc, 32'h0);
      end
      if (int'(fq_count) > maxcnt) maxcnt = int'(fq_count);
    end
    chk("t1_maxcount_le2", maxcnt <= 2, 1);
    ic_valid = 1'b0;
    repeat (3) tick();

    // Fill to full with decode stalled, then release.
    rst = 1'b1; tick(); rst = 1'b0;
    ic_valid = 1'b1; dec_ready = 1'b0;
    repeat (6) tick();
    chk("t2_full_count", fq_count, 4);
    chk("t2_full_req", ic_req, 0);
    chk("t2_full_addr", ic_addr, 32'h10);
    dec_ready = 1'b1;
    tick();
    chk("t2_req_after_pop", ic_req, 1);
    repeat (2) tick();
    ic_valid = 1'b0;
    repeat (5) tick();

    // Five-cycle miss at 0x40.
    redirect = 1'b1; redirect_pc = 32'h40; tick(); redirect = 1'b0;
    stall0 = stall_cycles;
    ic_valid = 1'b0; ic_stall = 1'b1;
    repeat (5) tick();
    chk("t3_stall_delta", stall_cycles - stall0, 5);
    chk("t3_addr_held", ic_addr, 32'h40);
    chk("t3_no_push", fq_count, 0);
    ic_stall = 1'b0; ic_valid = 1'b1;
    tick();
    chk("t3_hit_push", fq_count, 1);
    ic_valid = 1'b0;
    repeat (2) tick();

    // Redirect to 0x1003 with three entries queued and a same-cycle hit.
    dec_ready = 1'b0; ic_valid = 1'b1;
    repeat (3) tick();
    chk("t4_three_queued", fq_count, 3);
    redirect = 1'b1; redirect_pc = 32'h1003; dec_ready = 1'b1;
    tick();
    redirect = 1'b0; ic_valid = 1'b0;
    chk("t4_flush_count", fq_count, 0);
    chk("t4_flush_valid", dec_valid, 0);
    chk("t4_new_addr", ic_addr, 32'h1000);
    ic_valid = 1'b1;
    repeat (2) tick();
    ic_valid = 1'b0;
    repeat (2) tick();

    // fence_i to 0x200.
    fence_i = 1'b1; redirect_pc = 32'h200; ic_valid = 1'b1;
    tick();
    fence_i = 1'b0;
    chk("t5_inval_pulse", ic_invalidate, 1);
    chk("t5_req_low", ic_req, 0);
    tick();
    chk("t5_inval_done", ic_invalidate, 0);
    chk("t5_req_back", ic_req, 1);
    chk("t5_addr", ic_addr, 32'h200);
    repeat (2) tick();

    // Back-to-back fence_i: new target wins, pulse repeats; then fence with redirect.
    fence_i = 1'b1; redirect_pc = 32'h280; tick();
    redirect_pc = 32'h300; tick();
    fence_i = 1'b0;
    chk("t5b_inval_repeat", ic_invalidate, 1);
    tick();
    chk("t5b_addr", ic_addr, 32'h300);
    fence_i = 1'b1; redirect = 1'b1; redirect_pc = 32'h404; tick();
    fence_i = 1'b0; redirect = 1'b0;
    tick();
    chk("t5c_addr", ic_addr, 32'h404);
    ic_valid = 1'b0;
    repeat (3) tick();

    // Reset during a miss with two entries queued.
    dec_ready = 1'b0; ic_valid = 1'b1;
    repeat (2) tick();
    ic_valid = 1'b0; ic_stall = 1'b1;
    repeat (2) tick();
    rst = 1'b1; tick(); rst = 1'b0; ic_stall = 1'b0;
    chk("t6_count", fq_count, 0);
    chk("t6_addr", ic_addr, 32'h0);
    chk("t6_inval", ic_invalidate, 0);
    chk("t6_stall", stall_cycles, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
